// File: rtl/rv32i_types.sv
// ============================================================================
// Module      : rv32i_types (package)
// Description : Shared RV32I front-end types. Carries the prediction_choice
//               enum used by the branch predictors, the default geometry of
//               the pattern history table and the counter reset-value helper.
// Revision    : 1.1 - added pattern history table constants and helper
// ============================================================================
`default_nettype none

package rv32i_types;

  // Direction prediction handed from the predictor to fetch.
  typedef enum logic {
    no_take = 1'b0,
    take    = 1'b1
  } prediction_choice;

  localparam int BPT_DEFAULT_ENTRIES   = 64;
  localparam int BPT_DEFAULT_CTR_WIDTH = 2;

  // Weakly-not-taken value for a counter of ctr_width bits: the largest value
  // whose MSB is still 0. Evaluates to 0 for a 1-bit counter.
  function automatic int bpt_ctr_reset_val(input int ctr_width);
    return (1 << (ctr_width - 1)) - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bpt_sat_counter.sv
// ============================================================================
// Module      : bpt_sat_counter
// Description : Combinational saturating up/down counter step. Given the
//               current counter value and the resolved branch outcome it
//               produces the trained value and the prediction the current
//               value represents (its MSB).
// Ports       : cur   - current counter value
//               taken - resolved outcome, 1 = taken
//               nxt   - trained counter value (saturates at 0 and at all-ones)
//               pred  - prediction encoded by cur
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bpt_sat_counter
  import rv32i_types::*;
#(
  parameter int CTR_WIDTH = BPT_DEFAULT_CTR_WIDTH
) (
  input  logic [CTR_WIDTH-1:0] cur,
  input  logic                 taken,
  output logic [CTR_WIDTH-1:0] nxt,
  output prediction_choice     pred
);

  localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;

  always_comb begin
    nxt  = cur;
    pred = prediction_choice'(cur[CTR_WIDTH-1]);
    if (taken) begin
      if (cur != CTR_MAX) begin
        nxt = cur + CTR_WIDTH'(1);
      end
    end else begin
      if (cur != '0) begin
        nxt = cur - CTR_WIDTH'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/branch_pattern_table.sv
// ============================================================================
// Module      : branch_pattern_table
// Description : Pattern history table of ENTRIES saturating counters for the
//               fetch stage. The fetch PC is looked up combinationally; the
//               execute stage returns the looked-up index together with the
//               resolved outcome to train that entry.
// Ports       : clk, reset (async, active low), flush (sync clear)
//               pred_pc            - fetch PC to predict
//               pred_taken         - prediction for pred_pc (same cycle)
//               pred_idx           - table index used for pred_pc
//               update_valid/_idx/_taken - training request from execute
//               update_mispredict  - registered: pre-update prediction of the
//                                    trained entry disagreed with the outcome
//               ghr_out            - global history (BPT_GSHARE_EN only)
// Options     : `define BPT_GSHARE_EN to XOR a GHR_WIDTH-bit non-speculative
//               global history into the lookup index (gshare).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_pattern_table
  import rv32i_types::*;
#(
  parameter  int ENTRIES   = BPT_DEFAULT_ENTRIES,
  parameter  int CTR_WIDTH = BPT_DEFAULT_CTR_WIDTH,
  parameter  int GHR_WIDTH = 6,
  localparam int IDX_W     = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [31:0]      pred_pc,
  output prediction_choice pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             update_valid,
  input  logic [IDX_W-1:0] update_idx,
  input  logic             update_taken,
  output logic             update_mispredict
`ifdef BPT_GSHARE_EN
  ,
  output logic [GHR_WIDTH-1:0] ghr_out
`endif
);

  localparam logic [CTR_WIDTH-1:0] CTR_RESET = CTR_WIDTH'(bpt_ctr_reset_val(CTR_WIDTH));

  logic [CTR_WIDTH-1:0] table_q [ENTRIES];
  logic [CTR_WIDTH-1:0] table_d [ENTRIES];
  logic                 update_mispredict_q;
  logic                 update_mispredict_d;

  logic [IDX_W-1:0]     pc_idx;
  logic [CTR_WIDTH-1:0] ctr_next;
  prediction_choice     ctr_old_pred;

  // Word-aligned PC: bits [1:0] and everything above the index are not used.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0]};

  assign pc_idx = pred_pc[IDX_W+1:2];

  // Single training path: the entry named by update_idx is stepped once.
  bpt_sat_counter #(
    .CTR_WIDTH (CTR_WIDTH)
  ) u_sat_counter (
    .cur   (table_q[update_idx]),
    .taken (update_taken),
    .nxt   (ctr_next),
    .pred  (ctr_old_pred)
  );

  // Lookup reads the flops directly, so a same-cycle update to the same
  // entry is seen only after the edge.
  assign pred_taken        = prediction_choice'(table_q[pred_idx][CTR_WIDTH-1]);
  assign update_mispredict = update_mispredict_q;

  always_comb begin
    table_d             = table_q;
    update_mispredict_d = 1'b0;
    if (flush) begin
      // Flush dominates: a coincident update is discarded.
      for (int i = 0; i < ENTRIES; i++) begin
        table_d[i] = CTR_RESET;
      end
    end else if (update_valid) begin
      table_d[update_idx] = ctr_next;
      update_mispredict_d = (ctr_old_pred == take) != update_taken;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= CTR_RESET;
      end
      update_mispredict_q <= 1'b0;
    end else begin
      table_q             <= table_d;
      update_mispredict_q <= update_mispredict_d;
    end
  end

`ifdef BPT_GSHARE_EN
  logic [GHR_WIDTH-1:0] ghr_q;
  logic [GHR_WIDTH-1:0] ghr_d;

  // History is shifted with resolved outcomes only, so it never needs repair.
  always_comb begin
    ghr_d = ghr_q;
    if (flush) begin
      ghr_d = '0;
    end else if (update_valid) begin
      ghr_d = (ghr_q << 1) | GHR_WIDTH'(update_taken);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  // Training uses the returned update_idx, so later history shifts cannot
  // redirect an update to a different entry.
  assign pred_idx = pc_idx ^ IDX_W'(ghr_q);
  assign ghr_out  = ghr_q;
`else
  // History length only matters when gshare indexing is built in.
  logic [GHR_WIDTH-1:0] unused_ghr_width;
  assign unused_ghr_width = '0;

  assign pred_idx = pc_idx;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_pattern_table.sv
// ============================================================================
// Module      : tb_branch_pattern_table
// Description : Self-checking bench for branch_pattern_table. A default
//               instance (64 x 2-bit) and a 16 x 3-bit instance are driven
//               with directed and random training; expectations come from an
//               integer-array model of the counters and history.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_pattern_table;
  import rv32i_types::*;

  localparam int N   = 64;
  localparam int W   = 2;
  localparam int IW  = 6;
  localparam int GW  = 6;
  localparam int N3  = 16;
  localparam int W3  = 3;
  localparam int IW3 = 4;
  localparam int GW3 = 4;
`ifdef BPT_GSHARE_EN
  localparam bit GSH = 1'b1;
`else
  localparam bit GSH = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             flush;
  logic [31:0]      pred_pc;
  prediction_choice pred_taken;
  logic [IW-1:0]    pred_idx;
  logic             update_valid;
  logic [IW-1:0]    update_idx;
  logic             update_taken;
  logic             update_mispredict;

  logic             flush3;
  logic [31:0]      pc3;
  prediction_choice taken3;
  logic [IW3-1:0]   idx3;
  logic             uv3;
  logic [IW3-1:0]   ui3;
  logic             ut3;
  logic             um3;
`ifdef BPT_GSHARE_EN
  logic [GW-1:0]    ghr_out;
  logic [GW3-1:0]   ghr3;
`endif

  int             m  [N];
  int             m3 [N3];
  logic [GW-1:0]  ghr_m;
  logic [GW3-1:0] g3;
  logic           exp_misp;
  logic           exp_misp3;
  int             checks = 0;
  int             errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  branch_pattern_table #(.ENTRIES(N), .CTR_WIDTH(W), .GHR_WIDTH(GW)) dut (
    .clk               (clk),
    .reset             (reset),
    .flush             (flush),
    .pred_pc           (pred_pc),
    .pred_taken        (pred_taken),
    .pred_idx          (pred_idx),
    .update_valid      (update_valid),
    .update_idx        (update_idx),
    .update_taken      (update_taken),
    .update_mispredict (update_mispredict)
`ifdef BPT_GSHARE_EN
    ,
    .ghr_out           (ghr_out)
`endif
  );

  branch_pattern_table #(.ENTRIES(N3), .CTR_WIDTH(W3), .GHR_WIDTH(GW3)) dut3 (
    .clk               (clk),
    .reset             (reset),
    .flush             (flush3),
    .pred_pc           (pc3),
    .pred_taken        (taken3),
    .pred_idx          (idx3),
    .update_valid      (uv3),
    .update_idx        (ui3),
    .update_taken      (ut3),
    .update_mispredict (um3)
`ifdef BPT_GSHARE_EN
    ,
    .ghr_out           (ghr3)
`endif
  );

  // ---------------- reference model ----------------
  function automatic int sat(input int v, input bit t, input int w);
    if (t) return (v < (1 << w) - 1) ? v + 1 : v;
    return (v > 0) ? v - 1 : 0;
  endfunction

  function automatic prediction_choice mpred(input int v, input int w);
    return (v >= (1 << (w - 1))) ? take : no_take;
  endfunction

  task automatic model_reset_main();
    for (int i = 0; i < N; i++) m[i] = (1 << (W - 1)) - 1;
    ghr_m = '0;
  endtask

  task automatic model_reset_small();
    for (int i = 0; i < N3; i++) m3[i] = (1 << (W3 - 1)) - 1;
    g3 = '0;
  endtask

  // Random PC whose lookup lands on table entry idx under the current history.
  function automatic logic [31:0] pc_of(input int idx);
    logic [31:0] p;
    p = $urandom;
    p[IW+1:2] = IW'(idx) ^ (GSH ? ghr_m : '0);
    return p;
  endfunction

  function automatic logic [31:0] pc3_of(input int idx);
    logic [31:0] p;
    p = $urandom;
    p[IW3+1:2] = IW3'(idx) ^ (GSH ? g3 : '0);
    return p;
  endfunction

  // Drive one training request, cross the edge, advance the model.
  task automatic upd(input int idx, input bit t);
    update_valid = 1'b1;
    update_idx   = IW'(idx);
    update_taken = t;
    @(posedge clk); #1;
    exp_misp     = (mpred(m[idx], W) == take) != t;
    m[idx]       = sat(m[idx], t, W);
    ghr_m        = {ghr_m[GW-2:0], t};
    update_valid = 1'b0;
  endtask

  task automatic upd3(input int idx, input bit t);
    uv3 = 1'b1;
    ui3 = IW3'(idx);
    ut3 = t;
    @(posedge clk); #1;
    exp_misp3 = (mpred(m3[idx], W3) == take) != t;
    m3[idx]   = sat(m3[idx], t, W3);
    g3        = {g3[GW3-2:0], t};
    uv3       = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; flush3 = 1'b0;
    pred_pc = '0; update_valid = 1'b0; update_idx = '0; update_taken = 1'b0;
    pc3 = '0; uv3 = 1'b0; ui3 = '0; ut3 = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_reset_main();
    model_reset_small();
    checks++;
    if (update_mispredict !== 1'b0) begin
      errors++; $display("FAIL reset_mispredict: got %b expected 0", update_mispredict);
    end
    for (int i = 0; i < N; i++) begin
      pred_pc = pc_of(i); #1;
      checks++;
      if (pred_taken !== no_take || pred_idx !== IW'(i)) begin
        errors++; $display("FAIL reset_lookup[%0d]: got pred %0d idx %0d expected pred 0 idx %0d", i, pred_taken, pred_idx, i);
      end
    end
    for (int i = 0; i < N3; i++) begin
      pc3 = pc3_of(i); #1;
      checks++;
      if (taken3 !== no_take) begin
        errors++; $display("FAIL reset_lookup_w3[%0d]: got %0d expected 0", i, taken3);
      end
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_training();
    bit seq_t [7] = '{1, 1, 1, 1, 1, 0, 0};
    bit seq_p [7] = '{1, 1, 1, 1, 1, 1, 0};
    for (int k = 0; k < 7; k++) begin
      upd(5, seq_t[k]);
      checks++;
      if (update_mispredict !== exp_misp) begin
        errors++; $display("FAIL train_mispredict step %0d: got %b expected %b", k, update_mispredict, exp_misp);
      end
      pred_pc = pc_of(5); #1;
      checks++;
      if (pred_taken !== prediction_choice'(seq_p[k]) || pred_idx !== 6'd5) begin
        errors++; $display("FAIL train_lookup step %0d: got pred %0d idx %0d expected pred %0d idx 5", k, pred_taken, pred_idx, seq_p[k]);
      end
    end
  endtask

  task automatic test_same_cycle();
    prediction_choice post [2] = '{take, no_take};
    upd(5, 1); upd(5, 1); upd(5, 1);   // entry 5 now strongly taken (3)
    for (int r = 0; r < 2; r++) begin
      pred_pc = pc_of(5);
      update_valid = 1'b1; update_idx = 6'd5; update_taken = 1'b0;
      #1;
      checks++;
      if (pred_taken !== take) begin
        errors++; $display("FAIL same_cycle_pre round %0d: got %0d expected 1", r, pred_taken);
      end
      @(posedge clk); #1;
      update_valid = 1'b0;
      m[5]  = sat(m[5], 1'b0, W);
      ghr_m = {ghr_m[GW-2:0], 1'b0};
      checks++;
      if (update_mispredict !== 1'b1) begin
        errors++; $display("FAIL same_cycle_mispredict round %0d: got %b expected 1", r, update_mispredict);
      end
      pred_pc = pc_of(5); #1;
      checks++;
      if (pred_taken !== post[r]) begin
        errors++; $display("FAIL same_cycle_post round %0d: got %0d expected %0d", r, pred_taken, post[r]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (update_mispredict !== 1'b0) begin
      errors++; $display("FAIL idle_mispredict: got %b expected 0", update_mispredict);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      logic [31:0]   pc;
      logic [IW-1:0] e;
      int            ui;
      bit            t;
      pc = $urandom;
      e  = pc[IW+1:2] ^ (GSH ? ghr_m : '0);
      pred_pc = pc; #1;
      checks++;
      if (pred_idx !== e) begin
        errors++; $display("FAIL rand_idx iter %0d: got %0d expected %0d", n, pred_idx, e);
      end
      checks++;
      if (pred_taken !== mpred(m[e], W)) begin
        errors++; $display("FAIL rand_pred iter %0d: got %0d expected %0d", n, pred_taken, mpred(m[e], W));
      end
      if ($urandom_range(0, 3) == 0) begin
        update_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (update_mispredict !== 1'b0) begin
          errors++; $display("FAIL rand_idle_mispredict iter %0d: got %b expected 0", n, update_mispredict);
        end
      end else begin
        ui = ($urandom_range(0, 1) == 0) ? int'(e) : int'($urandom_range(0, N - 1));
        t  = 1'($urandom_range(0, 1));
        upd(ui, t);
        checks++;
        if (update_mispredict !== exp_misp) begin
          errors++; $display("FAIL rand_mispredict iter %0d: got %b expected %b", n, update_mispredict, exp_misp);
        end
      end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      upd(i, 1); upd(i, 1); upd(i, 1);
    end
    flush = 1'b1;
    update_valid = 1'b1; update_idx = 6'd3;
    update_taken = (mpred(m[3], W) == take) ? 1'b0 : 1'b1;  // would mispredict
    @(posedge clk); #1;
    flush = 1'b0; update_valid = 1'b0;
    model_reset_main();
    checks++;
    if (update_mispredict !== 1'b0) begin
      errors++; $display("FAIL flush_mispredict: got %b expected 0", update_mispredict);
    end
    for (int i = 0; i < N; i++) begin
      pred_pc = pc_of(i); #1;
      checks++;
      if (pred_taken !== no_take || pred_idx !== IW'(i)) begin
        errors++; $display("FAIL flush_lookup[%0d]: got pred %0d idx %0d expected pred 0 idx %0d", i, pred_taken, pred_idx, i);
      end
    end
    upd(0, 1);
    pred_pc = pc_of(0); #1;
    checks++;
    if (pred_taken !== take) begin
      errors++; $display("FAIL flush_then_train: got %0d expected 1", pred_taken);
    end
  endtask

  task automatic test_small();
    bit seq_t [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    bit seq_p [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    pc3 = 32'h0000_003C; #1;
    checks++;
    if (idx3 !== 4'd15 || taken3 !== no_take) begin
      errors++; $display("FAIL w3_pc3c: got idx %0d pred %0d expected idx 15 pred 0", idx3, taken3);
    end
    pc3 = 32'h0000_0040; #1;
    checks++;
    if (idx3 !== 4'd0) begin
      errors++; $display("FAIL w3_pc40: got idx %0d expected 0", idx3);
    end
    for (int k = 0; k < 8; k++) begin
      upd3(15, seq_t[k]);
      checks++;
      if (um3 !== exp_misp3) begin
        errors++; $display("FAIL w3_mispredict step %0d: got %b expected %b", k, um3, exp_misp3);
      end
      pc3 = pc3_of(15); #1;
      checks++;
      if (taken3 !== prediction_choice'(seq_p[k])) begin
        errors++; $display("FAIL w3_lookup step %0d: got %0d expected %0d", k, taken3, seq_p[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    upd(7, (mpred(m[7], W) == take) ? 1'b0 : 1'b1);
    checks++;
    if (update_mispredict !== 1'b1) begin
      errors++; $display("FAIL async_setup_mispredict: got %b expected 1", update_mispredict);
    end
    update_valid = 1'b1; update_idx = 6'd9; update_taken = 1'b1;
    uv3 = 1'b1; ui3 = 4'd2; ut3 = 1'b1;
    #3 reset = 1'b0;
    #1;
    checks++;
    if (update_mispredict !== 1'b0) begin
      errors++; $display("FAIL async_mispredict: got %b expected 0", update_mispredict);
    end
    model_reset_main();
    model_reset_small();
    for (int i = 0; i < N; i++) begin
      pred_pc = pc_of(i); #1;
      checks++;
      if (pred_taken !== no_take || pred_idx !== IW'(i)) begin
        errors++; $display("FAIL async_lookup[%0d]: got pred %0d idx %0d expected pred 0 idx %0d", i, pred_taken, pred_idx, i);
      end
    end
    for (int i = 0; i < N3; i++) begin
      pc3 = pc3_of(i); #1;
      checks++;
      if (taken3 !== no_take) begin
        errors++; $display("FAIL async_lookup_w3[%0d]: got %0d expected 0", i, taken3);
      end
    end
    update_valid = 1'b0; uv3 = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

`ifdef BPT_GSHARE_EN
  task automatic test_gshare();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    model_reset_main();
    upd(10, 1); upd(11, 1); upd(12, 0); upd(13, 1);
    checks++;
    if (ghr_out !== 6'b001101) begin
      errors++; $display("FAIL gshare_ghr: got %b expected 001101", ghr_out);
    end
    pred_pc = 32'h0000_0020; #1;
    checks++;
    if (pred_idx !== 6'd5) begin
      errors++; $display("FAIL gshare_idx: got %0d expected 5", pred_idx);
    end
    upd(5, 1);
    checks++;
    if (ghr_out !== ghr_m) begin
      errors++; $display("FAIL gshare_ghr_after: got %b expected %b", ghr_out, ghr_m);
    end
    for (int i = 0; i < N; i++) begin
      pred_pc = pc_of(i); #1;
      checks++;
      if (pred_taken !== mpred(m[i], W) || pred_idx !== IW'(i)) begin
        errors++; $display("FAIL gshare_lookup[%0d]: got pred %0d idx %0d expected pred %0d idx %0d", i, pred_taken, pred_idx, mpred(m[i], W), i);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_training();
    test_same_cycle();
    test_random();
    test_flush();
    test_small();
    test_async_reset();
`ifdef BPT_GSHARE_EN
    test_gshare();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, expected to have finished", $time);
    $fatal(1);
  end

endmodule

`default_nettype wire
